ext_burst_ctrl: RTL and testbench
=================================

EXT_BURST_CTRL -- requirements
Module: ext_burst_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, write-data FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, WAIT-state watchdog limit (used only with EXT_BURST_TIMEOUT_EN).
REQ-003 SHALL have ports: clk_i  in  1  sole clock; reset_i  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: cfg_base_addr_i in 32, burst start byte address; cfg_count_i in 16, word count; cfg_write_i in 1, 1=write burst.
REQ-005 SHALL have ports: cmd_start_i in 1, start pulse; cmd_abort_i in 1, abort pulse.
REQ-006 SHALL have ports: wdata_i in 32; wdata_valid_i in 1; wdata_ready_o out 1 (write-FIFO push handshake).
REQ-007 SHALL have ports: rdata_o out 32; rdata_valid_o out 1; rdata_ready_i in 1 (read-data handshake).
REQ-008 SHALL have ports: tran_addr_o out 32; tran_data_o out 32; tran_size_o out 2; tran_start_o out 1; tran_write_o out 1; tran_clear_o out 1; tran_data_i in 32; tran_ready_i in 1 (SoC single-word transaction port).
REQ-009 SHALL have ports: busy_o out 1; done_o out 1; aborted_o out 1; error_o out 1; remaining_o out 16.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT, CLEAR.
REQ-011 IDLE: cmd_start_i with cfg_count_i!=0 SHALL latch address, count, direction and enter FETCH next cycle; cfg_count_i==0 SHALL be ignored.
REQ-012 cmd_start_i outside IDLE SHALL be ignored.
REQ-013 FETCH: write burst SHALL wait for FIFO non-empty, read burst for rdata slot empty (rdata_valid_o==0), then enter ISSUE.
REQ-014 ISSUE: tran_start_o SHALL be 1 for exactly one cycle with tran_addr_o, tran_data_o (FIFO head), tran_write_o stable; FIFO pop on this cycle.
REQ-015 tran_addr_o, tran_data_o, tran_write_o SHALL stay stable from ISSUE until CLEAR exits.
REQ-016 tran_size_o SHALL be constant 2'b10 (32-bit word).
REQ-017 WAIT: on tran_ready_i==1, read bursts SHALL capture tran_data_i into rdata_o, set rdata_valid_o, enter CLEAR.
REQ-018 CLEAR: tran_clear_o SHALL pulse one cycle on entry; SHALL stay in CLEAR until tran_ready_i==0, then decrement count, add 4 to address (modulo 2^32 wrap), enter FETCH, or IDLE if count reaches 0.
REQ-019 done_o SHALL pulse one cycle on every return to IDLE from a burst.
REQ-020 cmd_abort_i in FETCH SHALL go to IDLE next cycle; in ISSUE/WAIT/CLEAR SHALL complete the current word through CLEAR then go to IDLE; aborted_o SHALL pulse with done_o; abort in IDLE ignored.
REQ-021 Abort SHALL flush the write FIFO on return to IDLE.
REQ-022 Write FIFO full: wdata_ready_o=0; push and pop in the same cycle when full SHALL be accepted.
REQ-023 rdata_valid_o SHALL clear on rdata_valid_o&&rdata_ready_i unless a new capture occurs the same cycle.
REQ-024 busy_o SHALL be 1 in every state except IDLE; remaining_o SHALL show words not yet completed.

Reset
REQ-025 reset_i low SHALL asynchronously force IDLE, empty FIFO, and all outputs to 0 (tran_size_o still 2'b10), including mid-transaction; no clear pulse issued.

Configuration
REQ-026 With EXT_BURST_TIMEOUT_EN defined, a counter SHALL run in WAIT; reaching TIMEOUT_CYCLES SHALL pulse tran_clear_o, set sticky error_o, flush FIFO, go to IDLE with done_o pulse; error_o cleared by next accepted cmd_start_i.
REQ-027 Without EXT_BURST_TIMEOUT_EN, error_o SHALL be tied 0 and WAIT SHALL wait indefinitely.

Structure
REQ-028 FSM state encoding, TRAN_SIZE_WORD constant and address increment (4) SHALL live in shared package ext_burst_pkg.
REQ-029 Write FIFO SHALL be sub-module ext_burst_fifo (synchronous, async active-low reset).

Verification
REQ-030 Write burst base 0x0000_0100, count 3, FIFO preloaded 0xA,0xB,0xC, ready after 2 cycles -> starts at 0x100/0x104/0x108 with data A/B/C, 3 clear pulses, one done_o.
REQ-031 Read burst base 0x0, count 2, rdata_ready_i held 0 -> second ISSUE withheld until first word popped; rdata_o sequence matches tran_data_i.
REQ-032 Base 0xFFFF_FFFC, count 2 -> second address 0x0000_0000.
REQ-033 Abort during WAIT of word 2 of 4 -> word 2 completes with clear, IDLE, done_o+aborted_o, remaining_o=2, FIFO empty.
REQ-034 reset_i low during WAIT -> immediate IDLE, all outputs 0, FIFO empty; cfg_count_i=0 start -> busy_o stays 0.
REQ-035 EXT_BURST_TIMEOUT_EN, TIMEOUT_CYCLES=16, tran_ready_i never set -> clear pulse after 16 WAIT cycles, error_o=1, done_o pulse.

Source files
------------

// File: rtl/ext_burst_pkg.sv
// Shared definitions for the external burst controller: FSM encoding,
// transaction size code and per-word address step.
package ext_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam logic [1:0]  TRAN_SIZE_WORD = 2'b10;
    localparam logic [31:0] ADDR_INCR      = 32'd4;

    // Word-aligned address step; wraps naturally at 2^32.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + ADDR_INCR;
    endfunction

endpackage

// File: rtl/ext_burst_fifo.sv
// Write-data FIFO for the burst controller. A push into a full FIFO is
// accepted when a pop happens in the same cycle; flush empties it at once.
module ext_burst_fifo
    import ext_burst_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ext_burst_ctrl.sv
// Burst controller that turns a base/count command into single-word SoC
// transactions. Optional WAIT watchdog enabled by EXT_BURST_TIMEOUT_EN.
module ext_burst_ctrl
    import ext_burst_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] cfg_base_addr_i,
    input  logic [15:0] cfg_count_i,
    input  logic        cfg_write_i,
    input  logic        cmd_start_i,
    input  logic        cmd_abort_i,
    input  logic [31:0] wdata_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    input  logic        rdata_ready_i,
    output logic [31:0] tran_addr_o,
    output logic [31:0] tran_data_o,
    output logic [1:0]  tran_size_o,
    output logic        tran_start_o,
    output logic        tran_write_o,
    output logic        tran_clear_o,
    input  logic [31:0] tran_data_i,
    input  logic        tran_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        aborted_o,
    output logic        error_o,
    output logic [15:0] remaining_o
);

`ifdef EXT_BURST_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t      state_q;
    logic [31:0] addr_q;
    logic [15:0] cnt_q;
    logic        write_q;
    logic        abort_pend_q;
    logic [31:0] tran_addr_q, tran_data_q;
    logic        tran_write_q, tran_start_q, tran_clear_q;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        done_q, aborted_q, error_q;
    logic [TMO_W-1:0] tmo_q;

    logic        fifo_push, fifo_pop, fifo_flush;
    logic        fifo_empty, fifo_full;
    logic [31:0] fifo_head;
    logic        start_ok, fetch_go, word_done, abort_now;
    logic        fetch_abort, clear_abort, timeout_hit;

    assign start_ok    = cmd_start_i && (cfg_count_i != 16'd0);
    assign fetch_go    = write_q ? !fifo_empty : !rdata_valid_q;
    assign word_done   = (state_q == ST_CLEAR) && !tran_ready_i;
    assign abort_now   = abort_pend_q || cmd_abort_i;
    assign fetch_abort = (state_q == ST_FETCH) && cmd_abort_i;
    assign clear_abort = word_done && abort_now;
    assign timeout_hit = TMO_EN && (state_q == ST_WAIT) && !tran_ready_i &&
                         (tmo_q == TMO_LIMIT);

    // Abort and watchdog paths both discard any queued write data on the way to IDLE.
    assign fifo_flush    = fetch_abort || clear_abort || timeout_hit;
    assign fifo_pop      = (state_q == ST_ISSUE) && write_q;
    assign wdata_ready_o = reset_i && (!fifo_full || fifo_pop);
    assign fifo_push     = wdata_valid_i && wdata_ready_o;

    ext_burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_wfifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (wdata_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            abort_pend_q  <= 1'b0;
            tran_addr_q   <= '0;
            tran_data_q   <= '0;
            tran_write_q  <= 1'b0;
            tran_start_q  <= 1'b0;
            tran_clear_q  <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            error_q       <= 1'b0;
            tmo_q         <= '0;
        end else begin
            tran_start_q <= 1'b0;
            tran_clear_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            if (rdata_valid_q && rdata_ready_i) rdata_valid_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        addr_q       <= cfg_base_addr_i;
                        cnt_q        <= cfg_count_i;
                        write_q      <= cfg_write_i;
                        abort_pend_q <= 1'b0;
                        error_q      <= 1'b0;
                        state_q      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (cmd_abort_i) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (fetch_go) begin
                        tran_start_q <= 1'b1;
                        tran_addr_q  <= addr_q;
                        tran_data_q  <= write_q ? fifo_head : 32'd0;
                        tran_write_q <= write_q;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_abort_i) abort_pend_q <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cmd_abort_i) abort_pend_q <= 1'b1;
                    if (tran_ready_i) begin
                        if (!write_q) begin
                            rdata_q       <= tran_data_i;
                            rdata_valid_q <= 1'b1;
                        end
                        tran_clear_q <= 1'b1;
                        state_q      <= ST_CLEAR;
                    end else if (timeout_hit) begin
                        tran_clear_q <= 1'b1;
                        error_q      <= 1'b1;
                        done_q       <= 1'b1;
                        aborted_q    <= abort_now;
                        abort_pend_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (TMO_EN) begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end
                ST_CLEAR: begin
                    if (cmd_abort_i) abort_pend_q <= 1'b1;
                    // The word counts as completed only once the SoC drops ready.
                    if (!tran_ready_i) begin
                        cnt_q  <= cnt_q - 16'd1;
                        addr_q <= next_word_addr(addr_q);
                        if (abort_now || (cnt_q == 16'd1)) begin
                            done_q       <= 1'b1;
                            aborted_q    <= abort_now;
                            abort_pend_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tran_size_o   = TRAN_SIZE_WORD;
    assign tran_addr_o   = tran_addr_q;
    assign tran_data_o   = tran_data_q;
    assign tran_write_o  = tran_write_q;
    assign tran_start_o  = tran_start_q;
    assign tran_clear_o  = tran_clear_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign aborted_o     = aborted_q;
    assign error_o       = error_q;
    assign remaining_o   = cnt_q;

endmodule

// File: tb/tb_ext_burst_ctrl.sv
// Directed bench for ext_burst_ctrl with a transaction scoreboard and an
// auto-responding SoC model; timeout scenario runs when EXT_BURST_TIMEOUT_EN is set.
module tb_ext_burst_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] cfg_base_addr_i;
    logic [15:0] cfg_count_i;
    logic        cfg_write_i;
    logic        cmd_start_i, cmd_abort_i;
    logic [31:0] wdata_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, rdata_ready_i;
    logic [31:0] tran_addr_o, tran_data_o;
    logic [1:0]  tran_size_o;
    logic        tran_start_o, tran_write_o, tran_clear_o;
    logic [31:0] tran_data_i;
    logic        tran_ready_i;
    logic        busy_o, done_o, aborted_o, error_o;
    logic [15:0] remaining_o;

    always #5 clk_i = ~clk_i;

    ext_burst_ctrl #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_count_i     (cfg_count_i),
        .cfg_write_i     (cfg_write_i),
        .cmd_start_i     (cmd_start_i),
        .cmd_abort_i     (cmd_abort_i),
        .wdata_i         (wdata_i),
        .wdata_valid_i   (wdata_valid_i),
        .wdata_ready_o   (wdata_ready_o),
        .rdata_o         (rdata_o),
        .rdata_valid_o   (rdata_valid_o),
        .rdata_ready_i   (rdata_ready_i),
        .tran_addr_o     (tran_addr_o),
        .tran_data_o     (tran_data_o),
        .tran_size_o     (tran_size_o),
        .tran_start_o    (tran_start_o),
        .tran_write_o    (tran_write_o),
        .tran_clear_o    (tran_clear_o),
        .tran_data_i     (tran_data_i),
        .tran_ready_i    (tran_ready_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .aborted_o       (aborted_o),
        .error_o         (error_o),
        .remaining_o     (remaining_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
    } tran_t;

    tran_t       exp_tran_q[$];
    logic [31:0] exp_rd_q[$];

    int checks = 0;
    int failures = 0;
    int starts = 0, clears = 0, dones = 0, aborts = 0;
    int resp_cnt = 0, resp_delay = 2;
    bit resp_en = 1'b1;
    logic cur_wr = 1'b0;
    logic [31:0] held_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, run the SoC responder and the scoreboard.
    task automatic tick();
        tran_t t;
        @(posedge clk_i);
        #1;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                tran_ready_i = 1'b1;
                if (!cur_wr) begin
                    tran_data_i = $urandom;
                    exp_rd_q.push_back(tran_data_i);
                end
            end
        end
        if (tran_start_o) begin
            starts++;
            cur_wr    = tran_write_o;
            held_addr = tran_addr_o;
            if (resp_en) resp_cnt = resp_delay;
            chk1("tran_expected", exp_tran_q.size() != 0, 1'b1);
            if (exp_tran_q.size() != 0) begin
                t = exp_tran_q.pop_front();
                chk("tran_addr", tran_addr_o, t.addr);
                chk1("tran_write", tran_write_o, t.wr);
                if (t.wr) chk("tran_data", tran_data_o, t.data);
                chk("tran_size", 32'(tran_size_o), 32'h2);
            end
        end
        if (tran_clear_o) begin
            clears++;
            tran_ready_i = 1'b0;
            chk("tran_addr_hold", tran_addr_o, held_addr);
        end
        if (done_o) begin
            dones++;
            if (aborted_o) aborts++;
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        chk1("wdata_ready", wdata_ready_o, 1'b1);
        wdata_valid_i = 1'b1;
        wdata_i       = d;
        tick();
        wdata_valid_i = 1'b0;
    endtask

    task automatic start(input logic [31:0] base, input logic [15:0] cnt, input logic wr);
        cfg_base_addr_i = base;
        cfg_count_i     = cnt;
        cfg_write_i     = wr;
        cmd_start_i     = 1'b1;
        tick();
        cmd_start_i     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = dones;
        int n = 0;
        while (dones == d0 && n < budget) begin
            tick();
            n++;
        end
        chk1(tag, dones != d0, 1'b1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int n = 0;
        while (starts < target && n < budget) begin
            tick();
            n++;
        end
        chk1(tag, starts >= target, 1'b1);
    endtask

    task automatic pop_rd(input string tag);
        int n = 0;
        while (!rdata_valid_o && n < 50) begin
            tick();
            n++;
        end
        chk1({tag, "_valid"}, rdata_valid_o, 1'b1);
        if (exp_rd_q.size() != 0) chk(tag, rdata_o, exp_rd_q.pop_front());
        rdata_ready_i = 1'b1;
        tick();
        rdata_ready_i = 1'b0;
        chk1({tag, "_cleared"}, rdata_valid_o, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_busy"}, busy_o, 1'b0);
        chk1({tag, "_done"}, done_o, 1'b0);
        chk1({tag, "_aborted"}, aborted_o, 1'b0);
        chk1({tag, "_error"}, error_o, 1'b0);
        chk1({tag, "_start"}, tran_start_o, 1'b0);
        chk1({tag, "_clear"}, tran_clear_o, 1'b0);
        chk1({tag, "_write"}, tran_write_o, 1'b0);
        chk1({tag, "_rvalid"}, rdata_valid_o, 1'b0);
        chk1({tag, "_wready"}, wdata_ready_o, 1'b0);
        chk({tag, "_addr"}, tran_addr_o, 32'h0);
        chk({tag, "_tdata"}, tran_data_o, 32'h0);
        chk({tag, "_rdata"}, rdata_o, 32'h0);
        chk({tag, "_remaining"}, 32'(remaining_o), 32'h0);
        chk({tag, "_size"}, 32'(tran_size_o), 32'h2);
    endtask

    initial begin
        int s0, c0, d0, a0;
        logic [31:0] d;

        reset_i = 1'b0;
        cfg_base_addr_i = '0;
        cfg_count_i = '0;
        cfg_write_i = 1'b0;
        cmd_start_i = 1'b0;
        cmd_abort_i = 1'b0;
        wdata_i = '0;
        wdata_valid_i = 1'b0;
        rdata_ready_i = 1'b0;
        tran_data_i = '0;
        tran_ready_i = 1'b0;
        tick();
        tick();
        chk_reset_outputs("por");
        reset_i = 1'b1;
        tick();
        chk1("ready_after_reset", wdata_ready_o, 1'b1);

        // Write burst of three words, SoC ready two cycles after each start
        push_word(32'hA);
        push_word(32'hB);
        push_word(32'hC);
        exp_tran_q.push_back('{32'h100, 32'hA, 1'b1});
        exp_tran_q.push_back('{32'h104, 32'hB, 1'b1});
        exp_tran_q.push_back('{32'h108, 32'hC, 1'b1});
        c0 = clears; d0 = dones; a0 = aborts;
        start(32'h100, 16'd3, 1'b1);
        chk1("wr_busy", busy_o, 1'b1);
        chk("wr_remaining_start", 32'(remaining_o), 32'd3);
        wait_done(100, "wr_done_seen");
        chk("wr_remaining_end", 32'(remaining_o), 32'd0);
        repeat (3) tick();
        chk("wr_clear_pulses", clears - c0, 32'd3);
        chk("wr_done_pulses", dones - d0, 32'd1);
        chk("wr_no_abort", aborts - a0, 32'd0);
        chk1("wr_idle", busy_o, 1'b0);

        // Read burst with rdata slot blocked
        exp_tran_q.push_back('{32'h0, 32'h0, 1'b0});
        exp_tran_q.push_back('{32'h4, 32'h0, 1'b0});
        s0 = starts;
        start(32'h0, 16'd2, 1'b0);
        begin
            int n = 0;
            while (!rdata_valid_o && n < 50) begin
                tick();
                n++;
            end
        end
        repeat (8) tick();
        chk("rd_second_withheld", starts - s0, 32'd1);
        pop_rd("rd_word0");
        wait_done(100, "rd_done_seen");
        pop_rd("rd_word1");

        // Address wrap at the top of the 32-bit space
        push_word(32'h1111_0000);
        push_word(32'h2222_0000);
        exp_tran_q.push_back('{32'hFFFF_FFFC, 32'h1111_0000, 1'b1});
        exp_tran_q.push_back('{32'h0000_0000, 32'h2222_0000, 1'b1});
        start(32'hFFFF_FFFC, 16'd2, 1'b1);
        wait_done(100, "wrap_done_seen");

        // Fill FIFO, then push while full during the first pop
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            push_word(d);
            exp_tran_q.push_back('{32'h2000 + 32'(i) * 32'd4, d, 1'b1});
        end
        chk1("fifo_full_not_ready", wdata_ready_o, 1'b0);
        s0 = starts;
        start(32'h2000, 16'd9, 1'b1);
        wait_starts(s0 + 1, 50, "full_first_start");
        chk1("full_pop_ready", wdata_ready_o, 1'b1);
        d = $urandom;
        wdata_valid_i = 1'b1;
        wdata_i = d;
        exp_tran_q.push_back('{32'h2020, d, 1'b1});
        tick();
        wdata_valid_i = 1'b0;
        wait_done(300, "full_done_seen");
        chk("full_remaining", 32'(remaining_o), 32'd0);

        // Abort during WAIT of word 2 of 4
        for (int i = 0; i < 4; i++) begin
            d = 32'h5000 + 32'(i);
            push_word(d);
            if (i < 2) exp_tran_q.push_back('{32'h300 + 32'(i) * 32'd4, d, 1'b1});
        end
        resp_delay = 6;
        s0 = starts; c0 = clears; a0 = aborts;
        start(32'h300, 16'd4, 1'b1);
        wait_starts(s0 + 2, 50, "abort_second_start");
        tick();
        cmd_abort_i = 1'b1;
        tick();
        cmd_abort_i = 1'b0;
        wait_done(50, "abort_done_seen");
        chk("abort_flagged", aborts - a0, 32'd1);
        chk("abort_remaining", 32'(remaining_o), 32'd2);
        chk("abort_clears", clears - c0, 32'd2);
        resp_delay = 2;
        s0 = starts;
        start(32'h400, 16'd1, 1'b1);
        repeat (5) tick();
        chk("abort_fifo_empty", starts - s0, 32'd0);
        chk1("fetch_stuck_busy", busy_o, 1'b1);
        cmd_abort_i = 1'b1;
        tick();
        cmd_abort_i = 1'b0;
        chk1("fetch_abort_done", done_o, 1'b1);
        chk1("fetch_abort_aborted", aborted_o, 1'b1);
        chk1("fetch_abort_idle", busy_o, 1'b0);

        // Reset in the middle of a read WAIT with write data queued
        push_word(32'hD1);
        push_word(32'hD2);
        resp_en = 1'b0;
        exp_tran_q.push_back('{32'h500, 32'h0, 1'b0});
        s0 = starts;
        start(32'h500, 16'd1, 1'b0);
        wait_starts(s0 + 1, 50, "rst_start");
        tick();
        c0 = clears;
        reset_i = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        chk("midrst_no_clear", clears - c0, 32'd0);
        reset_i = 1'b1;
        resp_en = 1'b1;
        tick();
        s0 = starts;
        start(32'h600, 16'd1, 1'b1);
        repeat (4) tick();
        chk("midrst_fifo_empty", starts - s0, 32'd0);
        cmd_abort_i = 1'b1;
        tick();
        cmd_abort_i = 1'b0;
        d0 = dones;
        start(32'h700, 16'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk1("zero_count_idle", busy_o, 1'b0);
            tick();
        end
        chk("zero_count_no_done", dones - d0, 32'd0);

`ifdef EXT_BURST_TIMEOUT_EN
        // Watchdog: SoC never answers
        resp_en = 1'b0;
        exp_tran_q.push_back('{32'h800, 32'h0, 1'b0});
        s0 = starts;
        start(32'h800, 16'd1, 1'b0);
        wait_starts(s0 + 1, 50, "tmo_start");
        begin
            int n = 0;
            while (!tran_clear_o && n < 40) begin
                tick();
                n++;
            end
            chk("tmo_cycles", n, 32'd17);
        end
        chk1("tmo_done", done_o, 1'b1);
        chk1("tmo_error", error_o, 1'b1);
        tick();
        chk1("tmo_error_sticky", error_o, 1'b1);
        chk1("tmo_idle", busy_o, 1'b0);
        resp_en = 1'b1;
        exp_tran_q.push_back('{32'h900, 32'h0, 1'b0});
        start(32'h900, 16'd1, 1'b0);
        chk1("tmo_error_cleared", error_o, 1'b0);
        wait_done(50, "tmo_next_done");
        pop_rd("tmo_next_rd");
`endif

        chk("scoreboard_tran_left", exp_tran_q.size(), 32'd0);
        chk("scoreboard_rd_left", exp_rd_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
